trig_counter_bank: RTL and testbench
====================================

TRIG_COUNTER_BANK -- requirements
Module: trig_counter_bank

Interface
REQ-001 SHALL have parameter LED_LSB, default 23, giving the count0 bit index that drives led[0].
REQ-002 SHALL have port ti_clk  input  1  sole clock; all logic is rising-edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port trig_in  input  16  one-cycle trigger pulses: [0] clear count1, [1] count1 up, [2] count1 down, [3] snapshot request, [4] clear count0; [15:5] ignored.
REQ-005 SHALL have port mode_in  input  16  static wire: [0] 1=saturate, 0=wrap; [15:8] count1 step, where 0 is treated as 1; [7:1] ignored.
REQ-006 SHALL have ports snap0_lo, snap0_hi, snap1_lo, snap1_hi  output  16 each  captured count0[15:0], count0[31:16], count1[15:0] and count1[31:16].
REQ-007 SHALL have port snap_valid  output  1  high while the snapshot registers are stable and coherent.
REQ-008 SHALL have port evt_out  output  16  one-cycle event pulses: [0] count1 overflow, [1] count1 underflow, [2] snapshot done, [3] snapshot request dropped; [15:4] are 0.
REQ-009 SHALL have port led  output  4  active-low display: ~count0[LED_LSB+3:LED_LSB].

Function
REQ-010 count0 (32 bit) SHALL increment by 1 every cycle and wrap from 0xFFFFFFFF to 0.
REQ-011 trig_in[4] SHALL make count0 equal 0 on the next cycle, overriding the increment.
REQ-012 count1 (32 bit) SHALL use the priority clear > (up XOR down); up and down asserted in the same cycle SHALL leave count1 unchanged.
REQ-013 Up SHALL add the zero-extended step; down SHALL subtract it; the result is visible the cycle after the trigger.
REQ-014 Wrap mode: results SHALL be taken modulo 2^32; evt_out[0] SHALL pulse when an up step carries out of bit 31; evt_out[1] SHALL pulse when a down step borrows.
REQ-015 Saturate mode: count1 SHALL clamp at 0xFFFFFFFF or 0; evt_out[0]/[1] SHALL pulse when the step would exceed the limit, including when count1 is already at the limit.
REQ-016 Clear SHALL never raise evt_out[0] or evt_out[1].
REQ-017 Snapshot FSM SHALL have states IDLE, CAPTURE and HOLD; reset state is IDLE.
REQ-018 In IDLE or HOLD, trig_in[3] at cycle N SHALL load the snap registers with the count0/count1 register values present at cycle N (pre-update); at N+1 the FSM is in CAPTURE with snap_valid=0.
REQ-019 CAPTURE SHALL move unconditionally to HOLD: at N+2 snap_valid=1 and evt_out[2]=1 for exactly one cycle.
REQ-020 trig_in[3] while in CAPTURE SHALL be ignored and SHALL pulse evt_out[3] on the next cycle.
REQ-021 HOLD SHALL persist with snap registers frozen until the next request; clearing or counting SHALL NOT alter the snap registers.
REQ-022 Each evt_out bit SHALL be registered and high for one cycle per causing event only.

Reset
REQ-023 With reset high at a clock edge, count0, count1, all snap outputs, snap_valid and evt_out SHALL be 0, the FSM SHALL be IDLE, and led SHALL be 4'hF on the next cycle.
REQ-024 Reset SHALL override every trigger in the same cycle; a snapshot in CAPTURE SHALL be abandoned with no evt_out[2] pulse.

Verification
REQ-025 Reset, then 100 idle cycles -> count0 reads 100 (±1 cycle sampling offset); count1=0; snap_valid=0; evt_out=0.
REQ-026 Wrap mode, step=0, count1=0xFFFFFFFF, up pulse -> count1=0 next cycle and a single evt_out[0] pulse.
REQ-027 Saturate mode, step=0x10, count1=5, down pulse -> count1=0 and evt_out[1] pulse; a further down -> count1 stays 0 and evt_out[1] pulses again.
REQ-028 count1=7, up and down in the same cycle -> count1=7 and no event; clear plus up -> count1=0.
REQ-029 Snapshot at cycle N with count0=0x0001FFFF -> snap0_hi=0x0001 and snap0_lo=0xFFFF; snap_valid rises at N+2 with evt_out[2]; a second request at N+1 -> evt_out[3] at N+2 and the snap values are unchanged.
REQ-030 Reset asserted at N+1 during CAPTURE -> snap_valid=0, snap registers 0, and no evt_out[2] pulse.

Source files
------------

// File: rtl/trig_counter_bank.sv
// trig_counter_bank: free-running counter (count0), triggered up/down counter
// (count1) with wrap/saturate modes, and a coherent snapshot of both.
//   ti_clk, reset      : rising-edge clock, synchronous active-high reset
//   trig_in            : [0] clr count1, [1] up, [2] down, [3] snapshot, [4] clr count0
//   mode_in            : [0] saturate, [15:8] count1 step (0 acts as 1)
//   snap0_*/snap1_*    : captured count0/count1 halves
//   snap_valid         : snapshot registers stable and coherent
//   evt_out            : [0] overflow, [1] underflow, [2] snap done, [3] snap dropped
//   led                : ~count0[LED_LSB+3:LED_LSB]
module trig_counter_bank #(
  parameter int LED_LSB = 23
) (
  input  logic        ti_clk,
  input  logic        reset,
  input  logic [15:0] trig_in,
  input  logic [15:0] mode_in,
  output logic [15:0] snap0_lo,
  output logic [15:0] snap0_hi,
  output logic [15:0] snap1_lo,
  output logic [15:0] snap1_hi,
  output logic        snap_valid,
  output logic [15:0] evt_out,
  output logic [3:0]  led
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } snap_state_t;

  snap_state_t state, state_nxt;

  logic [31:0] count0;
  logic [31:0] count1, count1_nxt;
  logic [7:0]  step;
  logic [32:0] sum, diff;
  logic        up, down, ovf, unf;
  logic        snap_load, snap_done, snap_drop;
  logic        unused_bits;

  assign unused_bits = ^{trig_in[15:5], mode_in[7:1]};

  assign step = (mode_in[15:8] == 8'd0) ? 8'd1 : mode_in[15:8];
  assign up   = trig_in[1] & ~trig_in[2];
  assign down = trig_in[2] & ~trig_in[1];
  assign sum  = {1'b0, count1} + {25'd0, step};
  assign diff = {1'b0, count1} - {25'd0, step};

  always_ff @(posedge ti_clk) begin
    if (reset)
      count0 <= '0;
    else if (trig_in[4])
      count0 <= '0;
    else
      count0 <= count0 + 32'd1;
  end

  // Carry/borrow out of the 33-bit add/sub flags the limit crossing in both modes.
  always_comb begin
    count1_nxt = count1;
    ovf        = 1'b0;
    unf        = 1'b0;
    if (trig_in[0]) begin
      count1_nxt = '0;
    end else if (up) begin
      ovf        = sum[32];
      count1_nxt = (sum[32] && mode_in[0]) ? '1 : sum[31:0];
    end else if (down) begin
      unf        = diff[32];
      count1_nxt = (diff[32] && mode_in[0]) ? '0 : diff[31:0];
    end
  end

  always_ff @(posedge ti_clk) begin
    if (reset)
      count1 <= '0;
    else
      count1 <= count1_nxt;
  end

  always_ff @(posedge ti_clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, HOLD: if (trig_in[3]) state_nxt = CAPTURE;
      CAPTURE:    state_nxt = HOLD;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    snap_load  = 1'b0;
    snap_done  = 1'b0;
    snap_drop  = 1'b0;
    snap_valid = 1'b0;
    case (state)
      IDLE:    snap_load = trig_in[3];
      CAPTURE: begin
        snap_done = 1'b1;
        snap_drop = trig_in[3];
      end
      HOLD: begin
        snap_valid = 1'b1;
        snap_load  = trig_in[3];
      end
      default: ;
    endcase
  end

  always_ff @(posedge ti_clk) begin
    if (reset) begin
      snap0_lo <= '0;
      snap0_hi <= '0;
      snap1_lo <= '0;
      snap1_hi <= '0;
    end else if (snap_load) begin
      snap0_lo <= count0[15:0];
      snap0_hi <= count0[31:16];
      snap1_lo <= count1[15:0];
      snap1_hi <= count1[31:16];
    end
  end

  always_ff @(posedge ti_clk) begin
    if (reset)
      evt_out <= '0;
    else
      evt_out <= {12'd0, snap_drop, snap_done, unf, ovf};
  end

  assign led = ~count0[LED_LSB+3:LED_LSB];

endmodule

// File: tb/tb_trig_counter_bank.sv
module tb_trig_counter_bank;

  logic        ti_clk = 1'b0;
  logic        reset;
  logic [15:0] trig_in;
  logic [15:0] mode_in;
  logic [15:0] snap0_lo, snap0_hi, snap1_lo, snap1_hi;
  logic        snap_valid;
  logic [15:0] evt_out;
  logic [3:0]  led;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 ti_clk = ~ti_clk;

  trig_counter_bank #(.LED_LSB(16)) dut (
    .ti_clk     (ti_clk),
    .reset      (reset),
    .trig_in    (trig_in),
    .mode_in    (mode_in),
    .snap0_lo   (snap0_lo),
    .snap0_hi   (snap0_hi),
    .snap1_lo   (snap1_lo),
    .snap1_hi   (snap1_hi),
    .snap_valid (snap_valid),
    .evt_out    (evt_out),
    .led        (led)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ti_clk);
    #1;
  endtask

  // Pulse a trigger for one cycle; events of that trigger are visible on return.
  task automatic pulse(input logic [15:0] t);
    trig_in = t;
    tick();
    trig_in = '0;
  endtask

  // Snapshot then wait for HOLD so both snap words are readable.
  task automatic snap_read();
    pulse(16'h0008);
    tick();
  endtask

  initial begin
    reset   = 1'b1;
    trig_in = '0;
    mode_in = '0;

    // Reset state
    tick();
    check("rst_snap0", {snap0_hi, snap0_lo}, 32'h0);
    check("rst_snap1", {snap1_hi, snap1_lo}, 32'h0);
    check("rst_valid", {31'd0, snap_valid}, 32'h0);
    check("rst_evt",   {16'd0, evt_out}, 32'h0);
    check("rst_led",   {28'd0, led}, 32'hF);

    // 100 idle cycles then snapshot: count0 captured as 100
    reset = 1'b0;
    repeat (100) tick();
    pulse(16'h0008);
    check("cap_valid", {31'd0, snap_valid}, 32'h0);
    check("cap_evt",   {16'd0, evt_out}, 32'h0);
    tick();
    check("idle_count0", {snap0_hi, snap0_lo}, 32'd100);
    check("idle_count1", {snap1_hi, snap1_lo}, 32'd0);
    check("hold_valid",  {31'd0, snap_valid}, 32'h1);
    check("done_evt",    {16'd0, evt_out}, 32'h0004);
    tick();
    check("done_once",   {16'd0, evt_out}, 32'h0);

    // Wrap: 0 - 1 underflows to all ones
    mode_in = 16'h0000;
    pulse(16'h0004);
    check("wrap_unf_evt", {16'd0, evt_out}, 32'h0002);
    snap_read();
    check("wrap_unf_val", {snap1_hi, snap1_lo}, 32'hFFFF_FFFF);
    // Wrap, step=0 acts as 1: all ones + 1 -> 0 with single overflow
    pulse(16'h0002);
    check("wrap_ovf_evt", {16'd0, evt_out}, 32'h0001);
    tick();
    check("wrap_ovf_once", {16'd0, evt_out}, 32'h0);
    snap_read();
    check("wrap_ovf_val", {snap1_hi, snap1_lo}, 32'h0);

    // Step 0x10 wrap up
    mode_in = 16'h1000;
    pulse(16'h0002);
    check("step_up_evt", {16'd0, evt_out}, 32'h0);
    snap_read();
    check("step_up_val", {snap1_hi, snap1_lo}, 32'h10);

    // Saturate: count1=5, down by 0x10 clamps at 0, twice
    pulse(16'h0001);
    check("clr_no_evt", {16'd0, evt_out}, 32'h0);
    mode_in = 16'h0501;
    pulse(16'h0002);
    mode_in = 16'h1001;
    pulse(16'h0004);
    check("sat_unf_evt", {16'd0, evt_out}, 32'h0002);
    pulse(16'h0004);
    check("sat_unf_evt2", {16'd0, evt_out}, 32'h0002);
    snap_read();
    check("sat_unf_val", {snap1_hi, snap1_lo}, 32'h0);

    // Saturate at top: reach all ones via wrap, then up clamps with overflow
    mode_in = 16'h0000;
    pulse(16'h0004);
    mode_in = 16'h0301;
    pulse(16'h0002);
    check("sat_ovf_evt", {16'd0, evt_out}, 32'h0001);
    snap_read();
    check("sat_ovf_val", {snap1_hi, snap1_lo}, 32'hFFFF_FFFF);

    // count1=7: up+down together is a no-op; clear+up clears
    mode_in = 16'h0700;
    pulse(16'h0001);
    pulse(16'h0002);
    pulse(16'h0006);
    check("updn_evt", {16'd0, evt_out}, 32'h0);
    snap_read();
    check("updn_val", {snap1_hi, snap1_lo}, 32'd7);
    pulse(16'h0003);
    check("clrup_evt", {16'd0, evt_out}, 32'h0);
    snap_read();
    check("clrup_val", {snap1_hi, snap1_lo}, 32'd0);

    // count1 = 9 for snapshot coherence test
    mode_in = 16'h0900;
    pulse(16'h0002);

    // Clear count0, run to 0x00010003, snapshot; second request in CAPTURE dropped
    pulse(16'h0010);
    repeat (32'h0001_0003) tick();
    trig_in = 16'h0008;
    tick();
    check("c0_cap_valid", {31'd0, snap_valid}, 32'h0);
    check("c0_cap_evt",   {16'd0, evt_out}, 32'h0);
    tick();
    trig_in = '0;
    check("c0_hi",       {16'd0, snap0_hi}, 32'h0001);
    check("c0_lo",       {16'd0, snap0_lo}, 32'h0003);
    check("c0_c1",       {snap1_hi, snap1_lo}, 32'd9);
    check("c0_valid",    {31'd0, snap_valid}, 32'h1);
    check("c0_done_drop",{16'd0, evt_out}, 32'h000C);
    check("led_map",     {28'd0, led}, 32'hE);
    tick();
    check("c0_evt_clear",{16'd0, evt_out}, 32'h0);

    // HOLD freezes snap registers across clears and counting
    pulse(16'h0011);
    pulse(16'h0002);
    tick();
    check("hold_snap0",  {snap0_hi, snap0_lo}, 32'h0001_0003);
    check("hold_snap1",  {snap1_hi, snap1_lo}, 32'd9);
    check("hold_valid2", {31'd0, snap_valid}, 32'h1);

    // Reset during CAPTURE abandons snapshot, overriding triggers
    pulse(16'h0008);
    reset   = 1'b1;
    trig_in = 16'h000A;
    tick();
    trig_in = '0;
    reset   = 1'b0;
    check("rstcap_valid", {31'd0, snap_valid}, 32'h0);
    check("rstcap_snap0", {snap0_hi, snap0_lo}, 32'h0);
    check("rstcap_snap1", {snap1_hi, snap1_lo}, 32'h0);
    check("rstcap_evt",   {16'd0, evt_out}, 32'h0);
    check("rstcap_led",   {28'd0, led}, 32'hF);
    tick();
    check("rstcap_nodone", {16'd0, evt_out}, 32'h0);
    check("rstcap_idle",   {31'd0, snap_valid}, 32'h0);
    snap_read();
    check("rstcap_c1", {snap1_hi, snap1_lo}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
